// File: rtl/disparity_filter_pkg.sv
// Shared widths, sum-width helpers and FSM state codes for the disparity normalizer.
package disparity_filter_pkg;

    localparam int unsigned CONF_W        = 8;
    localparam int unsigned DISP_BITS_DEF = 5;
    localparam int unsigned WIN_LEN_DEF   = 4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_DIVIDE = 1'b1;

    function automatic int unsigned dc_sum_w(input int unsigned disp_bits, input int unsigned ab);
        return CONF_W + disp_bits + ab;
    endfunction

    function automatic int unsigned c_sum_w(input int unsigned ab);
        return CONF_W + ab;
    endfunction

endpackage

// File: rtl/disparity_normalizer_if.sv
// Sample stream in / filtered disparity out bundle for disparity_normalizer.
interface disparity_normalizer_if
    import disparity_filter_pkg::*;
#(
    parameter int unsigned DISP_BITS = DISP_BITS_DEF
);
    logic [CONF_W+DISP_BITS-1:0] disp_conf_in;
    logic [CONF_W-1:0]           conf_in;
    logic                        in_valid;
    logic                        flush;
    logic [DISP_BITS-1:0]        disp_out;
    logic [CONF_W-1:0]           conf_out;
    logic                        out_valid;
    logic                        overrun_err;

    modport master (
        output disp_conf_in, conf_in, in_valid, flush,
        input  disp_out, conf_out, out_valid, overrun_err
    );

    modport slave (
        input  disp_conf_in, conf_in, in_valid, flush,
        output disp_out, conf_out, out_valid, overrun_err
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Restoring divider, one quotient bit per clock MSB first; quotient_c/done_c are valid on the final edge.
module seq_restoring_divider #(
    parameter int unsigned DIVIDEND_W = 16,
    parameter int unsigned DIVISOR_W  = 10,
    parameter int unsigned QUOT_W     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done_c,
    output logic [QUOT_W-1:0]     quotient_c
);
    localparam int unsigned SW = (QUOT_W > 1) ? $clog2(QUOT_W) : 1;
    localparam int unsigned CW = DIVIDEND_W + DIVISOR_W;

    logic                  active_q, active_d;
    logic [SW-1:0]         step_q, step_d;
    logic [DIVIDEND_W-1:0] rem_q, rem_d;
    logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
    logic [QUOT_W-1:0]     quo_q, quo_d;
    logic                  ovf_q, ovf_d;

    logic [SW-1:0]         shift_c;
    logic [CW-1:0]         trial_c;
    logic                  fits_c;
    logic [QUOT_W-1:0]     quo_next_c;

    assign busy = active_q;

    always_comb begin
        shift_c    = SW'(QUOT_W - 1) - step_q;
        trial_c    = CW'(dsr_q) << shift_c;
        fits_c     = CW'(rem_q) >= trial_c;
        quo_next_c = {quo_q[QUOT_W-2:0], fits_c};
        done_c     = active_q && (step_q == SW'(QUOT_W - 1));
        // zero divisor reports 0; a quotient too wide for QUOT_W saturates
        if (dsr_q == '0) begin
            quotient_c = '0;
        end else if (ovf_q) begin
            quotient_c = '1;
        end else begin
            quotient_c = quo_next_c;
        end

        active_d = active_q;
        step_d   = step_q;
        rem_d    = rem_q;
        dsr_d    = dsr_q;
        quo_d    = quo_q;
        ovf_d    = ovf_q;
        if (active_q) begin
            step_d = step_q + 1'b1;
            quo_d  = quo_next_c;
            if (fits_c) begin
                rem_d = rem_q - DIVIDEND_W'(trial_c);
            end
            if (done_c) begin
                active_d = 1'b0;
            end
        end
        if (start) begin
            active_d = 1'b1;
            step_d   = '0;
            rem_d    = dividend;
            dsr_d    = divisor;
            quo_d    = '0;
            ovf_d    = CW'(dividend >> QUOT_W) >= CW'(divisor);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            step_q   <= '0;
            rem_q    <= '0;
            dsr_q    <= '0;
            quo_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            step_q   <= step_d;
            rem_q    <= rem_d;
            dsr_q    <= dsr_d;
            quo_q    <= quo_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: rtl/disparity_normalizer.sv
// Confidence-weighted window average of the disparity stream.
// Define DISP_NORM_ROUND_EN for round-half-up quotients; default build truncates.
module disparity_normalizer
    import disparity_filter_pkg::*;
#(
    parameter int unsigned disp_bits = DISP_BITS_DEF,
    parameter int unsigned win_len   = WIN_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    disparity_normalizer_if.slave  bus
);
    localparam int unsigned AB    = $clog2(win_len);
    localparam int unsigned DC_W  = dc_sum_w(disp_bits, AB);
    localparam int unsigned C_W   = c_sum_w(AB);
    localparam int unsigned DVD_W = DC_W + 1;

    logic [DC_W-1:0]      dc_sum_q, dc_sum_d;
    logic [C_W-1:0]       c_sum_q, c_sum_d;
    logic [AB-1:0]        cnt_q, cnt_d;
    logic [0:0]           state_q, state_d;
    logic [disp_bits-1:0] disp_out_q, disp_out_d;
    logic [CONF_W-1:0]    conf_out_q, conf_out_d;
    logic [CONF_W-1:0]    conf_pend_q, conf_pend_d;
    logic                 out_valid_q, out_valid_d;
    logic                 overrun_q, overrun_d;

    logic [DC_W-1:0]      dc_total_c;
    logic [C_W-1:0]       c_total_c;
    logic [DVD_W-1:0]     dividend_c;
    logic                 win_done_c;
    logic                 busy_c;
    logic                 start_c;
    logic                 div_busy;
    logic                 div_done_c;
    logic [disp_bits-1:0] quot_c;

    seq_restoring_divider #(
        .DIVIDEND_W (DVD_W),
        .DIVISOR_W  (C_W),
        .QUOT_W     (disp_bits)
    ) u_div (
        .clk        (clk),
        .rst_n      (reset_n),
        .start      (start_c),
        .dividend   (dividend_c),
        .divisor    (c_total_c),
        .busy       (div_busy),
        .done_c     (div_done_c),
        .quotient_c (quot_c)
    );

    always_comb begin
        dc_total_c = dc_sum_q + DC_W'(bus.disp_conf_in);
        c_total_c  = c_sum_q + C_W'(bus.conf_in);
        win_done_c = bus.in_valid && !bus.flush && (cnt_q == AB'(win_len - 1));
        // the divider's final edge can already take the next window
        busy_c     = div_busy && !div_done_c;
        start_c    = win_done_c && !busy_c;
`ifdef DISP_NORM_ROUND_EN
        dividend_c = DVD_W'(dc_total_c) + DVD_W'(c_total_c >> 1);
`else
        dividend_c = DVD_W'(dc_total_c);
`endif

        dc_sum_d    = dc_sum_q;
        c_sum_d     = c_sum_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        disp_out_d  = disp_out_q;
        conf_out_d  = conf_out_q;
        conf_pend_d = conf_pend_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q || (win_done_c && busy_c);

        if (bus.flush || win_done_c) begin
            dc_sum_d = '0;
            c_sum_d  = '0;
            cnt_d    = '0;
        end else if (bus.in_valid) begin
            dc_sum_d = dc_total_c;
            c_sum_d  = c_total_c;
            cnt_d    = cnt_q + 1'b1;
        end

        if (start_c) begin
            conf_pend_d = CONF_W'(c_total_c >> AB);
        end

        case (state_q)
            ST_IDLE:   if (start_c) state_d = ST_DIVIDE;
            ST_DIVIDE: if (div_done_c && !start_c) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (state_q == ST_DIVIDE && div_done_c) begin
            out_valid_d = 1'b1;
            disp_out_d  = quot_c;
            conf_out_d  = conf_pend_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dc_sum_q    <= '0;
            c_sum_q     <= '0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            disp_out_q  <= '0;
            conf_out_q  <= '0;
            conf_pend_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            dc_sum_q    <= dc_sum_d;
            c_sum_q     <= c_sum_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            disp_out_q  <= disp_out_d;
            conf_out_q  <= conf_out_d;
            conf_pend_q <= conf_pend_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.disp_out    = disp_out_q;
    assign bus.conf_out    = conf_out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.overrun_err = overrun_q;
endmodule

// File: tb/tb_disparity_normalizer.sv
// Scoreboard bench for disparity_normalizer (disp_bits=5, win_len=4); follows DISP_NORM_ROUND_EN.
module tb_disparity_normalizer;
    import disparity_filter_pkg::*;

    localparam int unsigned DB = 5;
    localparam int unsigned WL = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    disparity_normalizer_if #(.DISP_BITS(DB)) bus ();

    disparity_normalizer #(.disp_bits(DB), .win_len(WL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned d;
        int unsigned c;
        int unsigned at;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int total = 0;
    int bad   = 0;

    int unsigned m_dc = 0, m_c = 0, m_n = 0, m_free = 0;
    logic m_ovr = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Result monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset_n && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                got_e = sb.pop_front();
                check_val("disp_out", 32'(bus.disp_out), got_e.d);
                check_val("conf_out", 32'(bus.conf_out), got_e.c);
                check_val("latency", cyc, got_e.at);
            end
        end
    end

    task automatic model_clear();
        m_dc = 0;
        m_c  = 0;
        m_n  = 0;
    endtask

    // Drive one cycle of input and advance the reference model
    task automatic step(input logic v, input logic fl, input int unsigned dc, input int unsigned c);
        int unsigned e;
        int unsigned dvd;
        exp_t x;
        bus.in_valid     = v;
        bus.flush        = fl;
        bus.disp_conf_in = 13'(dc);
        bus.conf_in      = 8'(c);
        e = cyc + 1;
        if (fl) begin
            model_clear();
        end else if (v) begin
            m_dc += dc;
            m_c  += c;
            m_n++;
            if (m_n == WL) begin
                if (e >= m_free) begin
                    dvd = m_dc;
`ifdef DISP_NORM_ROUND_EN
                    dvd += m_c / 2;
`endif
                    x.d = (m_c == 0) ? 0 : dvd / m_c;
                    if (x.d > 31) x.d = 31;
                    x.c  = m_c / WL;
                    x.at = e + DB;
                    sb.push_back(x);
                    m_free = e + DB;
                end else begin
                    m_ovr = 1'b1;
                end
                model_clear();
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic window(input int unsigned dc, input int unsigned c);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, dc, c);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_disp"}, 32'(bus.disp_out), 32'd0);
        check_val({tag, "_conf"}, 32'(bus.conf_out), 32'd0);
        check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check_val({tag, "_ovr"}, 32'(bus.overrun_err), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sb.delete();
        model_clear();
        m_free = 0;
        m_ovr  = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.flush        = 1'b0;
        bus.disp_conf_in = '0;
        bus.conf_in      = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;
        @(negedge clk);

        // uniform window: 4000/400
        window(1000, 100);
        idle(8);

        // weighted: 350/100
        step(1'b1, 1'b0, 150, 50);
        step(1'b1, 1'b0, 200, 50);
        step(1'b1, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        idle(8);

        // zero confidence
        window(0, 0);
        idle(8);

        // back-to-back windows: second one lands while busy
        window(1000, 100);
        window(620, 200);
        idle(8);
        check_val("overrun_set", 32'(bus.overrun_err), 32'(m_ovr));
        do_reset();

        // one-cycle gap: second window completes on the final divide edge
        window(1000, 100);
        idle(1);
        window(310, 10);
        idle(8);
        check_val("overrun_clear", 32'(bus.overrun_err), 32'(m_ovr));

        // reset two cycles into a divide
        window(1000, 100);
        idle(2);
        do_reset();
        idle(8);
        window(1000, 100);
        idle(8);

        // partial window flushed, flush cycle carries a sample too
        step(1'b1, 1'b0, 5000, 250);
        step(1'b1, 1'b0, 5000, 250);
        step(1'b1, 1'b1, 5000, 250);
        window(620, 200);
        idle(8);

        // random windows with random gaps
        for (int w = 0; w < 24; w++) begin
            for (int s = 0; s < 4; s++) begin
                int unsigned d, c;
                d = $urandom_range(0, 31);
                c = $urandom_range(0, 255);
                step(1'b1, 1'b0, d * c, c);
                if ($urandom_range(0, 4) == 0) idle(1);
            end
            idle($urandom_range(0, 6));
        end
        idle(10);
        check_val("overrun_random", 32'(bus.overrun_err), 32'(m_ovr));
        check_val("drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
